alu_rsv_station: RTL and testbench
==================================

// Module: alu_rsv_station
// PURPOSE
//  Reservation station that sits directly upstream of the ALU.
//  - Buffers dispatched integer ops until both source operands are available.
//  - Captures operand values broadcast on the common data bus (CDB).
//  - Issues the oldest ready entry each cycle as an aluInStruct to the ALU
//    (combinational, always accepts).
//  - Carries dst_tag/rob_idx alongside the issued op for writeback.
// PARAMETERS
//  DEPTH     8   number of station entries (power of 2, >=2)
//  TAG_W     6   physical register tag width
//  ROB_W     5   ROB index width
// PORTS
//  clk            in   1      clock, all state on posedge
//  rst_n          in   1      asynchronous reset, active low
//  flush          in   1      squash all entries and the issue register
//  disp_valid     in   1      dispatch request
//  disp_ready     out  1      free entry exists (registered state)
//  disp_ctrl      in   4      ALUCtrl code
//  disp_alusrc    in   1      1: operand B is imm, src2 ignored
//  disp_imm       in   32     immediate
//  disp_s1_tag    in   TAG_W  src1 producer tag
//  disp_s1_rdy    in   1      src1 value already valid
//  disp_s1_val    in   32     src1 value (used when rdy)
//  disp_s2_tag    in   TAG_W  src2 producer tag
//  disp_s2_rdy    in   1      src2 value already valid
//  disp_s2_val    in   32     src2 value
//  disp_dst_tag   in   TAG_W  destination tag
//  disp_rob_idx   in   ROB_W  ROB slot
//  cdb_valid      in   1      CDB broadcast valid
//  cdb_tag        in   TAG_W  broadcast tag
//  cdb_value      in   32     broadcast value
//  issue_out      out  aluInStruct  rs1, rs2, imm, ALUSrc, ALUCtrl, valid to ALU
//  issue_dst_tag  out  TAG_W  dst tag of issued op
//  issue_rob_idx  out  ROB_W  ROB slot of issued op
//  occupancy      out  $clog2(DEPTH)+1  valid entry count
// BEHAVIOUR
//  - Reset (rst_n=0, async):
//    - All entries invalid; issue_out zeroed with valid=0.
//    - issue_dst_tag/issue_rob_idx = 0; occupancy = 0; disp_ready = 1.
//  - Dispatch: accepted on posedge when disp_valid && disp_ready && !flush.
//    - Op is written into the lowest-index free entry.
//    - disp_alusrc=1 forces src2 ready; rs2 is stored as 0.
//    - Same-cycle bypass: if a source is not rdy and cdb_valid with cdb_tag
//      equal to its tag, the entry is written ready with cdb_value.
//  - Wakeup: each posedge, every valid entry operand with rdy=0 and tag==cdb_tag
//    (cdb_valid=1) captures cdb_value and sets rdy.
//    - Both operands of one entry may wake on the same broadcast.
//  - Select/issue: registered, 1-cycle latency.
//    - At each posedge, the oldest valid entry whose sources are both ready in
//      the current registered state is loaded into the issue register.
//    - That entry is freed. The issue register holds valid=0 if no entry is ready.
//    - issue_out.valid is high for exactly one cycle per issued op.
//  - Age: oldest = earliest accepted dispatch.
//    - Order must be exact across frees and reuse of entries, e.g. an age
//      matrix or per-entry sequence.
//  - Timing bounds:
//    - No wakeup-to-select bypass. Operand woken at edge N is selectable at
//      edge N+1 and visible on issue_out in the cycle after N+1.
//    - Dispatch-ready entry written at edge N is issued at edge N+1 at the earliest.
//  - disp_ready = (occupancy < DEPTH), from registered state only.
//    - A same-cycle issue does not admit a dispatch into a full station.
//    - Dispatch and issue in the same cycle leave occupancy unchanged.
//  - flush: at posedge, all entries are invalidated and issue valid cleared.
//    - Any concurrent dispatch is dropped.
//    - occupancy = 0 in the next cycle.
//  - Reset asserted mid-operation discards all state immediately (async).
//  - Assertions:
//    - occupancy never exceeds DEPTH.
//    - issue_out.valid never issues an entry with an unready operand.
// TESTING
//  - Ready op: dispatch ADD s1_val=5 s2_val=7, both rdy, at edge 0.
//    -> issue_out.valid=1 after edge 1 with rs1=5, rs2=7, ALUCtrl=0010.
//  - Wakeup: dispatch SUB s1 rdy=9, s2 tag=12 not rdy; cdb tag=12 value=4 at edge 3.
//    -> issue after edge 4 with rs2=4.
//    -> no issue after edge 3.
//  - Bypass: dispatch with s1 tag=20 while cdb tag=20 value=0xFFFF0000 same cycle.
//    -> entry written ready; issued next edge with rs1=0xFFFF0000.
//  - Ordering: 3 ops A,B,C dispatched in order; A/C ready and B ready later.
//    -> issue order A then C then B.
//    -> after entry reuse, a new op D is issued after an older ready op.
//  - Full: dispatch DEPTH=8 unready ops -> disp_ready=0, occupancy=8.
//    - Extra disp_valid is ignored.
//    - One wakeup+issue -> disp_ready=1 the following cycle.
//  - Flush: 5 pending entries plus a concurrent dispatch with flush=1.
//    -> next cycle occupancy=0, issue_out.valid=0.
//    -> later CDB of old tags causes no issue.

Source files
------------

// File: rtl/alu_rsv_station.sv
// Reservation station feeding the ALU: holds dispatched ops until both
// operands are available, snoops the CDB for operand values, and issues the
// oldest ready entry through a one-cycle issue register.

package alu_rsv_pkg;
    typedef struct packed {
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic        ALUSrc;
        logic [3:0]  ALUCtrl;
        logic        valid;
    } aluInStruct;
endpackage

module alu_rsv_station
    import alu_rsv_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int TAG_W = 6,
    parameter int ROB_W = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       disp_valid,
    output logic                       disp_ready,
    input  logic [3:0]                 disp_ctrl,
    input  logic                       disp_alusrc,
    input  logic [31:0]                disp_imm,
    input  logic [TAG_W-1:0]           disp_s1_tag,
    input  logic                       disp_s1_rdy,
    input  logic [31:0]                disp_s1_val,
    input  logic [TAG_W-1:0]           disp_s2_tag,
    input  logic                       disp_s2_rdy,
    input  logic [31:0]                disp_s2_val,
    input  logic [TAG_W-1:0]           disp_dst_tag,
    input  logic [ROB_W-1:0]           disp_rob_idx,
    input  logic                       cdb_valid,
    input  logic [TAG_W-1:0]           cdb_tag,
    input  logic [31:0]                cdb_value,
    output aluInStruct                 issue_out,
    output logic [TAG_W-1:0]           issue_dst_tag,
    output logic [ROB_W-1:0]           issue_rob_idx,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int OCC_W = IDX_W + 1;

    // Entry state (p0: the station array itself)
    logic [DEPTH-1:0] ent_vld_p0;
    logic [3:0]       ent_ctrl_p0   [DEPTH];
    logic             ent_alusrc_p0 [DEPTH];
    logic [31:0]      ent_imm_p0    [DEPTH];
    logic [TAG_W-1:0] ent_s1_tag_p0 [DEPTH];
    logic [TAG_W-1:0] ent_s2_tag_p0 [DEPTH];
    logic [DEPTH-1:0] ent_s1_rdy_p0;
    logic [DEPTH-1:0] ent_s2_rdy_p0;
    logic [31:0]      ent_s1_val_p0 [DEPTH];
    logic [31:0]      ent_s2_val_p0 [DEPTH];
    logic [TAG_W-1:0] ent_dst_p0    [DEPTH];
    logic [ROB_W-1:0] ent_rob_p0    [DEPTH];
    // age_p0[i][j] = 1 when entry i was accepted before entry j
    logic [DEPTH-1:0] age_p0        [DEPTH];

    // Issue register (p1)
    aluInStruct       issue_p1;
    logic [TAG_W-1:0] issue_dst_p1;
    logic [ROB_W-1:0] issue_rob_p1;

    logic [DEPTH-1:0] ent_ready;
    logic [DEPTH-1:0] sel_oh;
    logic [IDX_W-1:0] sel_idx;
    logic             any_sel;
    logic [IDX_W-1:0] free_idx;
    logic [DEPTH-1:0] free_oh;
    logic [OCC_W-1:0] occ_cnt;
    logic             disp_fire;

    // True when a not-yet-ready operand waiting on tag is satisfied by the CDB
    function automatic logic cdb_hit(input logic rdy, input logic [TAG_W-1:0] tag,
                                     input logic bvld, input logic [TAG_W-1:0] btag);
        return !rdy && bvld && (tag == btag);
    endfunction

    assign ent_ready = ent_vld_p0 & ent_s1_rdy_p0 & ent_s2_rdy_p0;

    // Oldest-ready select: an entry wins if no other ready entry is older
    always_comb begin
        sel_oh  = '0;
        sel_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            sel_oh[i] = ent_ready[i];
            for (int j = 0; j < DEPTH; j++) begin
                if (j != i && ent_ready[j] && age_p0[j][i]) sel_oh[i] = 1'b0;
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (sel_oh[i]) sel_idx = IDX_W'(i);
        end
    end

    assign any_sel = |sel_oh;

    // Lowest-index free entry and valid-entry count from registered state
    always_comb begin
        free_idx = '0;
        occ_cnt  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!ent_vld_p0[i]) free_idx = IDX_W'(i);
        end
        for (int i = 0; i < DEPTH; i++) begin
            occ_cnt = occ_cnt + OCC_W'(ent_vld_p0[i]);
        end
    end

    assign free_oh    = DEPTH'(1) << free_idx;
    assign occupancy  = occ_cnt;
    assign disp_ready = (occ_cnt < OCC_W'(DEPTH));
    assign disp_fire  = disp_valid && disp_ready && !flush;

    // Entry payload: dispatch write with CDB bypass, otherwise CDB wakeup
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (disp_fire && free_idx == IDX_W'(i)) begin
                ent_ctrl_p0[i]   <= disp_ctrl;
                ent_alusrc_p0[i] <= disp_alusrc;
                ent_imm_p0[i]    <= disp_imm;
                ent_dst_p0[i]    <= disp_dst_tag;
                ent_rob_p0[i]    <= disp_rob_idx;
                ent_s1_tag_p0[i] <= disp_s1_tag;
                ent_s2_tag_p0[i] <= disp_s2_tag;
                if (cdb_hit(disp_s1_rdy, disp_s1_tag, cdb_valid, cdb_tag)) begin
                    ent_s1_rdy_p0[i] <= 1'b1;
                    ent_s1_val_p0[i] <= cdb_value;
                end else begin
                    ent_s1_rdy_p0[i] <= disp_s1_rdy;
                    ent_s1_val_p0[i] <= disp_s1_val;
                end
                if (disp_alusrc) begin
                    ent_s2_rdy_p0[i] <= 1'b1;
                    ent_s2_val_p0[i] <= '0;
                end else if (cdb_hit(disp_s2_rdy, disp_s2_tag, cdb_valid, cdb_tag)) begin
                    ent_s2_rdy_p0[i] <= 1'b1;
                    ent_s2_val_p0[i] <= cdb_value;
                end else begin
                    ent_s2_rdy_p0[i] <= disp_s2_rdy;
                    ent_s2_val_p0[i] <= disp_s2_val;
                end
                // New entry is younger than everything already present
                age_p0[i] <= '0;
                for (int j = 0; j < DEPTH; j++) begin
                    if (j != i) age_p0[j][i] <= 1'b1;
                end
            end else begin
                if (ent_vld_p0[i] && cdb_hit(ent_s1_rdy_p0[i], ent_s1_tag_p0[i], cdb_valid, cdb_tag)) begin
                    ent_s1_rdy_p0[i] <= 1'b1;
                    ent_s1_val_p0[i] <= cdb_value;
                end
                if (ent_vld_p0[i] && cdb_hit(ent_s2_rdy_p0[i], ent_s2_tag_p0[i], cdb_valid, cdb_tag)) begin
                    ent_s2_rdy_p0[i] <= 1'b1;
                    ent_s2_val_p0[i] <= cdb_value;
                end
            end
        end
    end

    // Entry valids and issue register: free on issue, allocate on dispatch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_vld_p0   <= '0;
            issue_p1     <= '0;
            issue_dst_p1 <= '0;
            issue_rob_p1 <= '0;
        end else if (flush) begin
            ent_vld_p0     <= '0;
            issue_p1.valid <= 1'b0;
        end else begin
            ent_vld_p0     <= (ent_vld_p0 & ~sel_oh) | (disp_fire ? free_oh : '0);
            issue_p1.valid <= any_sel;
            if (any_sel) begin
                issue_p1.rs1     <= ent_s1_val_p0[sel_idx];
                issue_p1.rs2     <= ent_s2_val_p0[sel_idx];
                issue_p1.imm     <= ent_imm_p0[sel_idx];
                issue_p1.ALUSrc  <= ent_alusrc_p0[sel_idx];
                issue_p1.ALUCtrl <= ent_ctrl_p0[sel_idx];
                issue_dst_p1     <= ent_dst_p0[sel_idx];
                issue_rob_p1     <= ent_rob_p0[sel_idx];
            end
        end
    end

    assign issue_out     = issue_p1;
    assign issue_dst_tag = issue_dst_p1;
    assign issue_rob_idx = issue_rob_p1;

    // Sanity: occupancy bounded and selected entry has both operands ready
    always @(posedge clk) begin
        if (rst_n) begin
            assert (occ_cnt <= OCC_W'(DEPTH));
            if (any_sel) assert (ent_s1_rdy_p0[sel_idx] && ent_s2_rdy_p0[sel_idx]);
        end
    end

endmodule

// File: tb/tb_alu_rsv_station.sv
// Directed bench for alu_rsv_station with an in-order expected-issue queue.
module tb_alu_rsv_station;
    import alu_rsv_pkg::*;

    localparam int DEPTH = 8;
    localparam int TAG_W = 6;
    localparam int ROB_W = 5;

    logic clk, rst_n, flush;
    logic disp_valid, disp_ready;
    logic [3:0] disp_ctrl;
    logic disp_alusrc;
    logic [31:0] disp_imm;
    logic [TAG_W-1:0] disp_s1_tag, disp_s2_tag, disp_dst_tag;
    logic disp_s1_rdy, disp_s2_rdy;
    logic [31:0] disp_s1_val, disp_s2_val;
    logic [ROB_W-1:0] disp_rob_idx;
    logic cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [31:0] cdb_value;
    aluInStruct issue_out;
    logic [TAG_W-1:0] issue_dst_tag;
    logic [ROB_W-1:0] issue_rob_idx;
    logic [$clog2(DEPTH):0] occupancy;

    typedef struct {
        logic [31:0]      rs1;
        logic [31:0]      rs2;
        logic [3:0]       ctrl;
        logic [TAG_W-1:0] dst;
        logic [ROB_W-1:0] rob;
    } exp_t;

    exp_t sbq[$];
    int passed = 0;
    int total  = 0;

    alu_rsv_station #(.DEPTH(DEPTH), .TAG_W(TAG_W), .ROB_W(ROB_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_ctrl(disp_ctrl), .disp_alusrc(disp_alusrc), .disp_imm(disp_imm),
        .disp_s1_tag(disp_s1_tag), .disp_s1_rdy(disp_s1_rdy), .disp_s1_val(disp_s1_val),
        .disp_s2_tag(disp_s2_tag), .disp_s2_rdy(disp_s2_rdy), .disp_s2_val(disp_s2_val),
        .disp_dst_tag(disp_dst_tag), .disp_rob_idx(disp_rob_idx),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .issue_out(issue_out), .issue_dst_tag(issue_dst_tag),
        .issue_rob_idx(issue_rob_idx), .occupancy(occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic idle();
        disp_valid = 1'b0;
        cdb_valid  = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic disp(input logic [3:0] ctrl, input logic alusrc, input logic [31:0] imm,
                        input logic [TAG_W-1:0] t1, input logic r1, input logic [31:0] v1,
                        input logic [TAG_W-1:0] t2, input logic r2, input logic [31:0] v2,
                        input logic [TAG_W-1:0] dst, input logic [ROB_W-1:0] rob);
        disp_valid   = 1'b1;
        disp_ctrl    = ctrl;
        disp_alusrc  = alusrc;
        disp_imm     = imm;
        disp_s1_tag  = t1;
        disp_s1_rdy  = r1;
        disp_s1_val  = v1;
        disp_s2_tag  = t2;
        disp_s2_rdy  = r2;
        disp_s2_val  = v2;
        disp_dst_tag = dst;
        disp_rob_idx = rob;
    endtask

    task automatic cdb(input logic [TAG_W-1:0] t, input logic [31:0] v);
        cdb_valid = 1'b1;
        cdb_tag   = t;
        cdb_value = v;
    endtask

    task automatic push(input logic [31:0] rs1, input logic [31:0] rs2, input logic [3:0] ctrl,
                        input logic [TAG_W-1:0] dst, input logic [ROB_W-1:0] rob);
        sbq.push_back('{rs1: rs1, rs2: rs2, ctrl: ctrl, dst: dst, rob: rob});
    endtask

    // One clock edge; check issue valid, pop and compare any issued op, then go idle
    task automatic tick(input logic exp_vld);
        exp_t e;
        @(posedge clk);
        #1;
        chk("issue_valid", issue_out.valid, exp_vld);
        if (issue_out.valid) begin
            chk("sb_has_entry", sbq.size() != 0, 1);
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                chk("rs1", issue_out.rs1, e.rs1);
                chk("rs2", issue_out.rs2, e.rs2);
                chk("ctrl", issue_out.ALUCtrl, e.ctrl);
                chk("dst_tag", issue_dst_tag, e.dst);
                chk("rob_idx", issue_rob_idx, e.rob);
            end
        end
        idle();
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        disp(4'h0, 1'b0, 32'h0, '0, 1'b0, 32'h0, '0, 1'b0, 32'h0, '0, '0);
        disp_valid = 1'b0;
        cdb_tag = '0;
        cdb_value = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_issue_valid", issue_out.valid, 0);
        chk("rst_issue_rs1", issue_out.rs1, 0);
        chk("rst_dst_tag", issue_dst_tag, 0);
        chk("rst_rob_idx", issue_rob_idx, 0);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_disp_ready", disp_ready, 1);
        rst_n = 1'b1;

        // Ready op: ADD 5 + 7
        disp(4'b0010, 1'b0, 32'h0, 6'd0, 1'b1, 32'd5, 6'd0, 1'b1, 32'd7, 6'd1, 5'd1);
        push(32'd5, 32'd7, 4'b0010, 6'd1, 5'd1);
        tick(0);
        chk("ready_occ_1", occupancy, 1);
        tick(1);
        chk("ready_occ_0", occupancy, 0);
        tick(0);

        // Wakeup: SUB 9 - (tag 12)
        disp(4'b0110, 1'b0, 32'h0, 6'd0, 1'b1, 32'd9, 6'd12, 1'b0, 32'h0, 6'd2, 5'd2);
        tick(0);
        tick(0);
        cdb(6'd12, 32'd4);
        push(32'd9, 32'd4, 4'b0110, 6'd2, 5'd2);
        tick(0);
        tick(1);
        tick(0);

        // Same-cycle CDB bypass on src1
        disp(4'b0000, 1'b0, 32'h0, 6'd20, 1'b0, 32'h0, 6'd0, 1'b1, 32'd3, 6'd3, 5'd3);
        cdb(6'd20, 32'hFFFF_0000);
        push(32'hFFFF_0000, 32'd3, 4'b0000, 6'd3, 5'd3);
        tick(0);
        tick(1);

        // Immediate operand: src2 ignored and stored as zero
        disp(4'b0010, 1'b1, 32'd100, 6'd0, 1'b1, 32'd1, 6'd33, 1'b0, 32'hDEAD, 6'd4, 5'd4);
        push(32'd1, 32'd0, 4'b0010, 6'd4, 5'd4);
        tick(0);
        tick(1);
        chk("imm_field", issue_out.imm, 100);
        chk("alusrc_field", issue_out.ALUSrc, 1);

        // Ordering: A and C wake together, B later -> A, C, B
        disp(4'b0001, 1'b0, 32'h0, 6'd41, 1'b0, 32'h0, 6'd0, 1'b1, 32'd1, 6'd10, 5'd10);
        tick(0);
        disp(4'b0001, 1'b0, 32'h0, 6'd42, 1'b0, 32'h0, 6'd0, 1'b1, 32'd2, 6'd11, 5'd11);
        tick(0);
        disp(4'b0001, 1'b0, 32'h0, 6'd41, 1'b0, 32'h0, 6'd0, 1'b1, 32'd3, 6'd12, 5'd12);
        tick(0);
        cdb(6'd41, 32'hA);
        push(32'hA, 32'd1, 4'b0001, 6'd10, 5'd10);
        push(32'hA, 32'd3, 4'b0001, 6'd12, 5'd12);
        tick(0);
        tick(1);
        tick(1);
        cdb(6'd42, 32'hB);
        push(32'hB, 32'd2, 4'b0001, 6'd11, 5'd11);
        tick(0);
        tick(1);

        // Age across reuse: D lands in a lower index than older E, E must go first
        disp(4'b0111, 1'b0, 32'h0, 6'd52, 1'b0, 32'h0, 6'd0, 1'b1, 32'd20, 6'd20, 5'd20);
        tick(0);
        disp(4'b0111, 1'b0, 32'h0, 6'd50, 1'b0, 32'h0, 6'd0, 1'b1, 32'd21, 6'd21, 5'd21);
        tick(0);
        cdb(6'd52, 32'h52);
        push(32'h52, 32'd20, 4'b0111, 6'd20, 5'd20);
        tick(0);
        tick(1);
        disp(4'b0111, 1'b0, 32'h0, 6'd50, 1'b0, 32'h0, 6'd0, 1'b1, 32'd22, 6'd22, 5'd22);
        tick(0);
        cdb(6'd50, 32'h50);
        push(32'h50, 32'd21, 4'b0111, 6'd21, 5'd21);
        push(32'h50, 32'd22, 4'b0111, 6'd22, 5'd22);
        tick(0);
        tick(1);
        tick(1);
        tick(0);

        // Full station
        for (int i = 0; i < DEPTH; i++) begin
            disp(4'b0010, 1'b0, 32'h0, 6'(i + 1), 1'b0, 32'h0, 6'd0, 1'b1, 32'(i), 6'(30 + i), 5'(i));
            tick(0);
        end
        chk("full_occ", occupancy, DEPTH);
        chk("full_ready", disp_ready, 0);
        disp(4'b0010, 1'b0, 32'h0, 6'd0, 1'b1, 32'd77, 6'd0, 1'b1, 32'd77, 6'd60, 5'd30);
        tick(0);
        chk("full_extra_ignored", occupancy, DEPTH);
        cdb(6'd1, 32'd100);
        push(32'd100, 32'd0, 4'b0010, 6'd30, 5'd0);
        tick(0);
        chk("full_ready_after_wake", disp_ready, 0);
        tick(1);
        chk("after_issue_occ", occupancy, DEPTH - 1);
        chk("after_issue_ready", disp_ready, 1);
        cdb(6'd2, 32'd200);
        push(32'd200, 32'd1, 4'b0010, 6'd31, 5'd1);
        tick(0);
        disp(4'b0010, 1'b0, 32'h0, 6'd9, 1'b0, 32'h0, 6'd0, 1'b1, 32'd9, 6'd40, 5'd9);
        tick(1);
        chk("disp_issue_same_occ", occupancy, DEPTH - 1);

        // Flush with a pending select and a concurrent ready dispatch
        cdb(6'd3, 32'd300);
        tick(0);
        flush = 1'b1;
        disp(4'b0010, 1'b0, 32'h0, 6'd0, 1'b1, 32'd1, 6'd0, 1'b1, 32'd1, 6'd61, 5'd31);
        tick(0);
        chk("flush_occ", occupancy, 0);
        chk("flush_ready", disp_ready, 1);
        for (int t = 3; t <= 9; t++) begin
            cdb(6'(t), 32'(t));
            tick(0);
        end
        tick(0);
        tick(0);

        // Asynchronous reset mid-cycle
        disp(4'b0010, 1'b0, 32'h0, 6'd10, 1'b0, 32'h0, 6'd0, 1'b1, 32'd1, 6'd62, 5'd29);
        tick(0);
        chk("pre_reset_occ", occupancy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_occ", occupancy, 0);
        chk("async_reset_valid", issue_out.valid, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cdb(6'd10, 32'd5);
        tick(0);
        tick(0);
        chk("post_reset_occ", occupancy, 0);
        chk("sb_drained", sbq.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
